// File: rtl/ofm_write_burst_controller.sv
// Collects one tile of systolic-array output rows, requests per-channel base addresses
// from the OFM write address controller, then burst-writes each channel into OFM RAM.
module ofm_write_burst_controller #(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int OFM_RAM_SIZE  = 2205619,
    localparam int AW           = $clog2(OFM_RAM_SIZE)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [4:0]                         num_channels,
    input  logic                               data_in_valid,
    input  logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] data_in,
    output logic                               data_in_ready,
    output logic                               write,
    input  logic [AW-1:0]                      ofm_addr,
    input  logic [4:0]                         write_ofm_size,
    output logic                               ram_we,
    output logic [AW-1:0]                      ram_addr,
    output logic [DATA_WIDTH-1:0]              ram_wdata,
    output logic                               done
);
    localparam int         IW      = $clog2(SYSTOLIC_SIZE);
    localparam logic [4:0] MAX_CNT = 5'(SYSTOLIC_SIZE);

    // Counts are kept as (value - 1) so a full tile fits in IW bits.
    function automatic logic [IW-1:0] clamp_m1(input logic [4:0] v);
        logic [4:0] t;
        if (v == 5'd0)          t = 5'd0;
        else if (v > MAX_CNT)   t = MAX_CNT - 5'd1;
        else                    t = v - 5'd1;
        return t[IW-1:0];
    endfunction

    typedef enum logic [1:0] {IDLE, LOAD, ADDR, BURST} state_t;

    state_t                state;
    logic [IW-1:0]         n_m1, w_m1, row_cnt, ch, wi;
    logic                  more;
    logic [DATA_WIDTH-1:0] rows [SYSTOLIC_SIZE][SYSTOLIC_SIZE];
    logic [AW-1:0]         base [SYSTOLIC_SIZE];

    logic                  accept, capture;
    logic [IW-1:0]         n_now, beat_c, beat_i, beat_w, nxt_c, nxt_i;
    logic                  nxt_more;
    logic [AW-1:0]         beat_base, beat_addr;
    logic [DATA_WIDTH-1:0] beat_data;

    assign accept  = data_in_valid && data_in_ready && !start && (state == IDLE || state == LOAD);
    assign capture = (state == ADDR) && !start;
    assign n_now   = (state == IDLE) ? clamp_m1(num_channels) : n_m1;

    // Beat 0 is issued on the final address-capture edge, so its base and W may
    // still be on the inputs rather than in the tables.
    assign beat_c    = (state == BURST) ? ch : '0;
    assign beat_i    = (state == BURST) ? wi : '0;
    assign beat_w    = (state == ADDR && ch == '0) ? clamp_m1(write_ofm_size) : w_m1;
    assign beat_base = (state == ADDR && n_m1 == '0) ? ofm_addr : base[beat_c];
    assign beat_addr = beat_base + AW'(beat_i);
    assign beat_data = rows[beat_c][beat_i];

    always_comb begin
        nxt_c    = beat_c;
        nxt_i    = beat_i + IW'(1);
        nxt_more = 1'b1;
        if (beat_i == beat_w) begin
            nxt_i = '0;
            if (beat_c == n_m1) nxt_more = 1'b0;
            else                nxt_c    = beat_c + IW'(1);
        end
    end

    // Row buffer and address table: storage only, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < SYSTOLIC_SIZE; i++)
                rows[row_cnt][i] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
        if (capture) begin
            base[ch] <= ofm_addr;
            if (ch == '0) w_m1 <= clamp_m1(write_ofm_size);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE; data_in_ready <= 1'b0; write <= 1'b0; done <= 1'b0;
            ram_we <= 1'b0; ram_addr <= '0; ram_wdata <= '0;
            n_m1 <= '0; row_cnt <= '0; ch <= '0; wi <= '0; more <= 1'b0;
        end else if (start) begin
            state <= IDLE; data_in_ready <= 1'b0; write <= 1'b0; done <= 1'b0;
            ram_we <= 1'b0; ram_addr <= '0; ram_wdata <= '0;
            n_m1 <= '0; row_cnt <= '0; ch <= '0; wi <= '0; more <= 1'b0;
        end else begin
            write  <= 1'b0;
            done   <= 1'b0;
            ram_we <= 1'b0;
            case (state)
                IDLE, LOAD: begin
                    data_in_ready <= 1'b1;
                    if (accept) begin
                        if (state == IDLE) n_m1 <= n_now;
                        if (row_cnt == n_now) begin
                            state         <= ADDR;
                            data_in_ready <= 1'b0;
                            write         <= 1'b1;
                            row_cnt       <= '0;
                            ch            <= '0;
                        end else begin
                            state   <= LOAD;
                            row_cnt <= row_cnt + IW'(1);
                        end
                    end
                end
                ADDR: begin
                    if (ch == n_m1) begin
                        state     <= BURST;
                        ram_we    <= 1'b1;
                        ram_addr  <= beat_addr;
                        ram_wdata <= beat_data;
                        ch        <= nxt_c;
                        wi        <= nxt_i;
                        more      <= nxt_more;
                    end else begin
                        ch <= ch + IW'(1);
                    end
                end
                BURST: begin
                    if (more) begin
                        ram_we    <= 1'b1;
                        ram_addr  <= beat_addr;
                        ram_wdata <= beat_data;
                        ch        <= nxt_c;
                        wi        <= nxt_i;
                        more      <= nxt_more;
                    end else begin
                        state         <= IDLE;
                        done          <= 1'b1;
                        data_in_ready <= 1'b1;
                        ch            <= '0;
                        wi            <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ofm_write_burst_controller.sv
// Scoreboard bench: stimulus pushes expected beats and done timing; a monitor
// drives ofm_addr during address capture and checks every RAM write and done pulse.
module tb_ofm_write_burst_controller;
    localparam int SS = 16;
    localparam int DW = 16;
    localparam int AW = 22;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [4:0]         num_channels = '0;
    logic               data_in_valid = 1'b0;
    logic [SS*DW-1:0]   data_in = '0;
    logic               data_in_ready;
    logic               write;
    logic [AW-1:0]      ofm_addr = '0;
    logic [4:0]         write_ofm_size = '0;
    logic               ram_we;
    logic [AW-1:0]      ram_addr;
    logic [DW-1:0]      ram_wdata;
    logic               done;

    ofm_write_burst_controller dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_channels(num_channels),
        .data_in_valid(data_in_valid), .data_in(data_in), .data_in_ready(data_in_ready),
        .write(write), .ofm_addr(ofm_addr), .write_ofm_size(write_ofm_size),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            off;
    } beat_t;

    beat_t         beat_q[$];
    int            doff_q[$];
    logic [AW-1:0] cur_base [SS];
    int            cur_n = 0;
    int            cyc = 0;
    int            n_pass = 0, n_total = 0;
    bit            in_tile = 1'b0;
    int            t_write = 0, drv_idx = SS, beats_seen = 0, n_writes = 0;

    always @(posedge clk) cyc++;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int clampv(int v);
        if (v == 0) return 1;
        if (v > SS) return SS;
        return v;
    endfunction

    function automatic logic [DW-1:0] word_of(int tag, int c, int i);
        return DW'(tag*4096 + c*256 + i);
    endfunction

    always @(negedge clk) begin : monitor
        beat_t e;
        int    d;
        if (write) begin
            n_writes++;
            check("write_expected", 64'(doff_q.size() > 0 && !in_tile), 1);
            in_tile = 1'b1; t_write = cyc; drv_idx = 0; beats_seen = 0;
        end
        if (ram_we) begin
            if (beat_q.size() == 0) check("unexpected_beat", 1, 0);
            else begin
                e = beat_q.pop_front();
                check("beat_addr", ram_addr, e.addr);
                check("beat_data", ram_wdata, e.data);
                check("beat_time", cyc - t_write, e.off);
            end
            beats_seen++;
        end
        if (done) begin
            if (!in_tile || doff_q.size() == 0) check("unexpected_done", 1, 0);
            else begin
                d = doff_q.pop_front();
                check("done_time", cyc - t_write, d);
                check("beats_left_at_done", beat_q.size(), 0);
                in_tile = 1'b0;
            end
        end
        if (in_tile && drv_idx < cur_n) begin
            ofm_addr = cur_base[drv_idx];
            drv_idx++;
        end else begin
            ofm_addr = AW'($urandom);
        end
    end

    task automatic flush();
        beat_q.delete(); doff_q.delete(); in_tile = 1'b0; drv_idx = SS;
    endtask

    // Called at negedge+1; returns at negedge+1 of the first ADDR cycle.
    task automatic issue_tile(int nc, int w, int tag, int gap, int junk_hold);
        int    n = clampv(nc);
        int    ww = clampv(w);
        beat_t e;
        bit    r;
        int    guard;
        cur_n = n;
        for (int c = 0; c < n; c++)
            for (int i = 0; i < ww; i++) begin
                e.addr = cur_base[c] + AW'(i);
                e.data = word_of(tag, c, i);
                e.off  = n + c*ww + i;
                beat_q.push_back(e);
            end
        doff_q.push_back(n + n*ww);
        num_channels   = 5'(nc);
        write_ofm_size = 5'(w);
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < SS; i++) data_in[i*DW +: DW] = word_of(tag, c, i);
            data_in_valid = 1'b1;
            guard = 0;
            do begin
                r = data_in_ready;
                @(negedge clk); #1;
                guard++;
            end while (!r && guard < 100);
            if (!r) check("row_accept_timeout", 0, 1);
            if (c < n-1)
                for (int g = 0; g < gap; g++) begin
                    data_in_valid = 1'b0;
                    for (int i = 0; i < SS; i++) data_in[i*DW +: DW] = DW'($urandom);
                    @(negedge clk); #1;
                end
        end
        if (junk_hold > 0)
            for (int i = 0; i < SS; i++) data_in[i*DW +: DW] = DW'($urandom);
        else
            data_in_valid = 1'b0;
        check("write_after_last_row", write, 1);
        check("ready_low_in_addr", data_in_ready, 0);
        for (int k = 0; k < junk_hold; k++) begin
            @(negedge clk); #1;
            check("ready_low_while_busy", data_in_ready, 0);
        end
        data_in_valid = 1'b0;
    endtask

    task automatic wait_tile();
        int guard = 0;
        while ((in_tile || doff_q.size() > 0) && guard < 3000) begin
            @(negedge clk); #1;
            guard++;
        end
        if (guard >= 3000) begin
            check("tile_timeout", 0, 1);
            flush();
        end
        check("ready_after_done", data_in_ready, 1);
    endtask

    initial begin
        int guard;
        int w0;
        @(negedge clk); #1;
        check("rst_write", write, 0);
        check("rst_done", done, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_ready", data_in_ready, 0);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("ready_idle", data_in_ready, 1);

        cur_base[0] = 100; cur_base[1] = 269; cur_base[2] = 438;
        issue_tile(3, 16, 0, 0, 0);
        wait_tile();

        cur_base[0] = 5000;
        issue_tile(1, 13, 1, 0, 0);
        wait_tile();

        cur_base[0] = 7; cur_base[1] = 1000; cur_base[2] = 2000; cur_base[3] = 3000;
        issue_tile(4, 5, 2, 2, 4);
        wait_tile();

        cur_base[0] = 777;
        issue_tile(0, 20, 3, 0, 0);
        wait_tile();

        cur_base[0] = 300; cur_base[1] = 400;
        issue_tile(2, 8, 4, 0, 0);
        guard = 0;
        while (beats_seen < 6 && guard < 200) begin
            @(negedge clk); #1;
            guard++;
        end
        check("abort_reached_beat5", 64'(beats_seen), 6);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk); #1;
        check("abort_ram_we", ram_we, 0);
        check("abort_done", done, 0);
        check("abort_ready", data_in_ready, 0);
        flush();
        @(negedge clk); #1;
        check("abort_idle_ready", data_in_ready, 1);
        repeat (10) begin @(negedge clk); #1; end

        cur_base[0] = 50; cur_base[1] = 60;
        issue_tile(2, 3, 5, 0, 0);
        wait_tile();

        cur_base[0] = 900; cur_base[1] = 910; cur_base[2] = 920;
        issue_tile(3, 4, 6, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        check("arst_write", write, 0);
        check("arst_ram_we", ram_we, 0);
        check("arst_ready", data_in_ready, 0);
        check("arst_ram_addr", ram_addr, 0);
        check("arst_ram_wdata", ram_wdata, 0);
        check("arst_done", done, 0);
        flush();
        @(negedge clk); #1;
        rst_n = 1'b1;
        w0 = n_writes;
        repeat (30) begin @(negedge clk); #1; end
        check("no_write_after_reset", 64'(n_writes), 64'(w0));
        check("ready_after_reset", data_in_ready, 1);

        cur_base[0] = 22'h3FFFFE;
        issue_tile(1, 4, 7, 0, 0);
        wait_tile();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end
endmodule
